// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  // 40 MHz system clock, 921600 baud
  localparam int unsigned DEF_CLK_DIV = 43;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO; extra pointer MSB distinguishes full from empty.
module uart_rx_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_pop;
  logic             do_push;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // a pop in the same cycle frees the slot a full FIFO needs
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wptr[AW-1:0]] <= din;
        wptr              <= wptr + (AW+1)'(1);
      end
      if (do_pop) rptr <= rptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: oversampling-free mid-bit sampler feeding a flagged FIFO.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RX,
  input  logic                 clr_rdy,
  input  logic                 clr_err,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_perr,
  output logic                 rx_ferr,
  output logic                 rdy,
  output logic                 overrun
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);
  localparam int unsigned BIT_W = 4;
  localparam int unsigned ENT_W = DATA_BITS + 2;

  if (DATA_BITS < 5 || DATA_BITS > 9 || CLK_DIV < 8 || CLK_DIV > 4095 ||
      PARITY_EN > 1 || PARITY_ODD > 1 || STOP_BITS < 1 || STOP_BITS > 2 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $fatal(1, "uart_rx_cfg: illegal parameter value");
  end

  rx_state_t            state;
  rx_state_t            state_nx;
  logic                 smp;
  logic                 rx_s1;
  logic                 rx_s2;
  logic                 rx_prev;
  logic [CNT_W-1:0]     cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr;
  logic                 ferr;
  logic                 push_q;
  logic [ENT_W-1:0]     push_entry;
  logic [ENT_W-1:0]     head;
  logic                 fifo_full;
  logic                 fifo_empty;

  // Next state and sample strobe
  always_comb begin
    state_nx = state;
    smp      = 1'b0;
    case (state)
      IDLE: if (rx_prev && !rx_s2) state_nx = START;
      START: if (cnt == CNT_W'(CLK_DIV / 2)) begin
        smp      = 1'b1;
        state_nx = rx_s2 ? IDLE : DATA;
      end
      DATA: if (cnt == CNT_W'(CLK_DIV - 1)) begin
        smp = 1'b1;
        if (bit_cnt == BIT_W'(DATA_BITS - 1)) state_nx = (PARITY_EN != 0) ? PARITY : STOP;
      end
      PARITY: if (cnt == CNT_W'(CLK_DIV - 1)) begin
        smp      = 1'b1;
        state_nx = STOP;
      end
      STOP: if (cnt == CNT_W'(CLK_DIV - 1)) begin
        smp = 1'b1;
        if (bit_cnt == BIT_W'(STOP_BITS - 1)) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Synchronizer, baud/bit counters and frame assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_prev    <= 1'b1;
      cnt        <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      perr       <= 1'b0;
      ferr       <= 1'b0;
      push_q     <= 1'b0;
      push_entry <= '0;
    end else begin
      rx_s1   <= RX;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      push_q  <= 1'b0;

      if (state == IDLE || smp) cnt <= '0;
      else                      cnt <= cnt + CNT_W'(1);

      if (smp) bit_cnt <= (state_nx == state) ? bit_cnt + BIT_W'(1) : '0;

      if (smp) begin
        case (state)
          START: begin
            perr <= 1'b0;
            ferr <= 1'b0;
          end
          DATA:   shreg <= {rx_s2, shreg[DATA_BITS-1:1]};
          PARITY: perr  <= ((^shreg) ^ rx_s2) != 1'(PARITY_ODD);
          STOP: begin
            if (!rx_s2) ferr <= 1'b1;
            if (state_nx == IDLE) begin
              push_q     <= 1'b1;
              push_entry <= {ferr | ~rx_s2, perr, shreg};
            end
          end
          default: ;
        endcase
      end
    end
  end

  // A push into a full FIFO is lost unless a pop makes room in the same cycle
  always_ff @(posedge clk) begin
    if (rst)                                 overrun <= 1'b0;
    else if (push_q && fifo_full && !clr_rdy) overrun <= 1'b1;
    else if (clr_err)                        overrun <= 1'b0;
  end

  uart_rx_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_q),
    .pop   (clr_rdy),
    .din   (push_entry),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign {rx_ferr, rx_perr, rx_data} = head;
  assign rdy = !fifo_empty;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench: 8N1 receiver (u_a) and 8E1 receiver (u_b), CLK_DIV=16, FIFO_DEPTH=4.
module tb_uart_rx_cfg;
  import uart_pkg::*;

  localparam int unsigned DIV = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_a, rx_b;
  logic       clr_rdy, clr_err;
  logic [7:0] data_a, data_b;
  logic       perr_a, perr_b, ferr_a, ferr_b;
  logic       rdy_a, rdy_b, ovr_a, ovr_b;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  uart_rx_cfg #(.CLK_DIV(DIV), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .rst(rst), .RX(rx_a), .clr_rdy(clr_rdy), .clr_err(clr_err),
    .rx_data(data_a), .rx_perr(perr_a), .rx_ferr(ferr_a), .rdy(rdy_a), .overrun(ovr_a)
  );

  uart_rx_cfg #(.CLK_DIV(DIV), .FIFO_DEPTH(4), .PARITY_EN(1), .PARITY_ODD(0)) u_b (
    .clk(clk), .rst(rst), .RX(rx_b), .clr_rdy(clr_rdy), .clr_err(clr_err),
    .rx_data(data_b), .rx_perr(perr_b), .rx_ferr(ferr_b), .rdy(rdy_b), .overrun(ovr_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_line(input bit sel, input logic v);
    if (sel) rx_b = v;
    else     rx_a = v;
  endtask

  // One frame: start, 8 data bits LSB first, optional parity, one stop bit
  task automatic send(input bit sel, input logic [7:0] d, input bit par_en,
                      input logic par, input logic stop);
    set_line(sel, 1'b0);
    cycles(DIV);
    for (int i = 0; i < 8; i++) begin
      set_line(sel, d[i]);
      cycles(DIV);
    end
    if (par_en) begin
      set_line(sel, par);
      cycles(DIV);
    end
    set_line(sel, stop);
    cycles(DIV);
    set_line(sel, 1'b1);
  endtask

  task automatic pop;
    clr_rdy = 1'b1;
    cycles(1);
    clr_rdy = 1'b0;
  endtask

  int lat;

  initial begin
    rst = 1'b1; rx_a = 1'b1; rx_b = 1'b1; clr_rdy = 1'b0; clr_err = 1'b0;
    cycles(4);
    check("rst_rdy",  32'(rdy_a),  32'd0);
    check("rst_ovr",  32'(ovr_a),  32'd0);
    check("rst_data", 32'(data_a), 32'd0);
    check("rst_perr", 32'(perr_a), 32'd0);
    check("rst_ferr", 32'(ferr_a), 32'd0);
    rst = 1'b0;
    cycles(8);

    // 0xA5 8N1 with latency measured from the start edge
    lat = 0;
    fork
      send(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
      begin
        while (!rdy_a && lat < 300) begin
          cycles(1);
          lat++;
        end
      end
    join
    check("a5_latency_in_155_157", 32'(lat >= 155 && lat <= 157), 32'd1);
    check("a5_data", 32'(data_a), 32'hA5);
    check("a5_perr", 32'(perr_a), 32'd0);
    check("a5_ferr", 32'(ferr_a), 32'd0);
    pop();
    check("a5_pop_rdy", 32'(rdy_a), 32'd0);

    // 5-cycle glitch must be rejected
    rx_a = 1'b0;
    cycles(5);
    rx_a = 1'b1;
    cycles(40);
    check("glitch_rdy",   32'(rdy_a),   32'd0);
    check("glitch_state", 32'(u_a.state), 32'(IDLE));

    // Even parity: 0x03 with parity bit 1 is wrong, with 0 is right
    send(1'b1, 8'h03, 1'b1, 1'b1, 1'b1);
    cycles(4);
    check("par1_rdy",  32'(rdy_b),  32'd1);
    check("par1_data", 32'(data_b), 32'h03);
    check("par1_perr", 32'(perr_b), 32'd1);
    pop();
    send(1'b1, 8'h03, 1'b1, 1'b0, 1'b1);
    cycles(4);
    check("par0_data", 32'(data_b), 32'h03);
    check("par0_perr", 32'(perr_b), 32'd0);
    check("par0_ferr", 32'(ferr_b), 32'd0);
    pop();
    check("par_pop_rdy", 32'(rdy_b), 32'd0);

    // Framing error followed by a clean frame
    send(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
    cycles(2 * DIV);
    send(1'b0, 8'h12, 1'b0, 1'b0, 1'b1);
    cycles(4);
    check("ferr_data", 32'(data_a), 32'h55);
    check("ferr_flag", 32'(ferr_a), 32'd1);
    pop();
    check("ferr2_data", 32'(data_a), 32'h12);
    check("ferr2_flag", 32'(ferr_a), 32'd0);
    pop();
    check("ferr_pop_rdy", 32'(rdy_a), 32'd0);

    // Overrun: five frames into a four-entry FIFO
    for (int i = 1; i <= 5; i++) begin
      send(1'b0, 8'(i), 1'b0, 1'b0, 1'b1);
      cycles(DIV);
      if (i == 4) check("ovr_before", 32'(ovr_a), 32'd0);
    end
    check("ovr_set", 32'(ovr_a), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("ovr_pop%0d", i), 32'(data_a), 32'(i));
      pop();
    end
    check("ovr_empty", 32'(rdy_a), 32'd0);
    clr_err = 1'b1;
    cycles(1);
    clr_err = 1'b0;
    check("ovr_clr", 32'(ovr_a), 32'd0);

    // Reset during data bit 3 aborts the frame
    rx_a = 1'b0;
    cycles(DIV);
    rx_a = 1'b1; cycles(DIV);
    rx_a = 1'b0; cycles(DIV);
    rx_a = 1'b1; cycles(DIV);
    rx_a = 1'b0; cycles(DIV / 2);
    rst = 1'b1;
    cycles(3);
    rx_a = 1'b1;
    rst  = 1'b0;
    cycles(2 * DIV);
    check("abort_rdy",   32'(rdy_a),    32'd0);
    check("abort_state", 32'(u_a.state), 32'(IDLE));
    send(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
    cycles(4);
    check("abort_data", 32'(data_a), 32'h3C);
    pop();
    check("abort_single", 32'(rdy_a), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
